// File: rtl/adf4158_pkg.sv
// Shared constants, state encoding and register-index decode for the
// ADF4158 configuration receiver.
package adf4158_pkg;

  localparam int FRAME_W  = 32;
  localparam int NUM_REGS = 10;
  localparam int IDX_W    = 4;
  localparam int ADDR_W   = 3;
  localparam int SEL_BIT  = 23;

  localparam logic [IDX_W-1:0] IDX_R0    = 4'd0;
  localparam logic [IDX_W-1:0] IDX_R1    = 4'd1;
  localparam logic [IDX_W-1:0] IDX_R2    = 4'd2;
  localparam logic [IDX_W-1:0] IDX_R3    = 4'd3;
  localparam logic [IDX_W-1:0] IDX_R4    = 4'd4;
  localparam logic [IDX_W-1:0] IDX_R5_P1 = 4'd5;
  localparam logic [IDX_W-1:0] IDX_R5_P2 = 4'd6;
  localparam logic [IDX_W-1:0] IDX_R6_P1 = 4'd7;
  localparam logic [IDX_W-1:0] IDX_R6_P2 = 4'd8;
  localparam logic [IDX_W-1:0] IDX_R7    = 4'd9;

  // R0 / R1 field positions used for the decoded outputs
  localparam int R0_RAMP_BIT = 31;
  localparam int R0_INT_MSB  = 26;
  localparam int R0_INT_LSB  = 15;
  localparam int R0_FRAC_MSB = 14;
  localparam int R0_FRAC_LSB = 3;
  localparam int R1_FRAC_MSB = 27;
  localparam int R1_FRAC_LSB = 15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LATCH
  } rx_state_e;

  // R5 and R6 are double-buffered in the part; bit 23 picks the bank half
  function automatic logic [IDX_W-1:0] decode_idx(input logic [FRAME_W-1:0] w);
    logic [ADDR_W-1:0] a;
    a = w[ADDR_W-1:0];
    case (a)
      3'd0:    return IDX_R0;
      3'd1:    return IDX_R1;
      3'd2:    return IDX_R2;
      3'd3:    return IDX_R3;
      3'd4:    return IDX_R4;
      3'd5:    return w[SEL_BIT] ? IDX_R5_P1 : IDX_R5_P2;
      3'd6:    return w[SEL_BIT] ? IDX_R6_P1 : IDX_R6_P2;
      default: return IDX_R7;
    endcase
  endfunction

endpackage

// File: rtl/adf4158_pin_sync.sv
// Multi-stage synchronizer for one asynchronous pin, with rise/fall
// detection on the synchronized value.
module adf4158_pin_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Reset preloads the whole history so no edge appears right after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign sync = chain[STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/adf4158_cfg_rx.sv
// Receive side of the ADF4158 CLK/DATA/LE interface: oversamples the pins,
// assembles 32-bit frames and keeps a shadow copy of every register.
module adf4158_cfg_rx
  import adf4158_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sclk,
  input  logic                sdata,
  input  logic                le,
  output logic [FRAME_W-1:0]  word_o,
  output logic                word_valid,
  output logic [IDX_W-1:0]    word_idx,
  output logic                frame_err,
  output logic [NUM_REGS-1:0] reg_written,
  output logic                all_written,
  output logic                ramp_en,
  output logic [11:0]         int_o,
  output logic [24:0]         frac_o
);

  localparam int               CNT_W    = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic le_s, le_rise, le_fall;
  logic sdata_s, sdata_rise, sdata_fall;

  adf4158_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(sclk), .sync(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  adf4158_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_le (
    .clk(clk), .rst(rst), .din(le), .sync(le_s), .rise(le_rise), .fall(le_fall)
  );

  adf4158_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdata (
    .clk(clk), .rst(rst), .din(sdata), .sync(sdata_s), .rise(sdata_rise), .fall(sdata_fall)
  );

  rx_state_e            state_q, state_d;
  logic [FRAME_W-1:0]   shifter;
  logic [CNT_W-1:0]     bit_cnt;
  logic [FRAME_W-1:0]   bank [NUM_REGS];
  logic [IDX_W-1:0]     commit_idx;
  logic                 start_frame, shift_en, commit, discard;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (le_fall) state_d = ST_SHIFT;
      ST_SHIFT: if (le_rise) state_d = ST_LATCH;
      ST_LATCH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // A coincident le rise suppresses the sclk edge sampled in the same cycle
  always_comb begin
    start_frame = (state_q == ST_IDLE) && le_fall;
    shift_en    = (state_q == ST_SHIFT) && sclk_rise && !le_rise;
    commit      = (state_q == ST_LATCH) && (bit_cnt == CNT_FULL);
    discard     = (state_q == ST_LATCH) && (bit_cnt != CNT_FULL);
  end

  assign commit_idx = decode_idx(shifter);

  always_ff @(posedge clk) begin
    if (rst) begin
      shifter     <= '0;
      bit_cnt     <= '0;
      word_o      <= '0;
      word_idx    <= '0;
      word_valid  <= 1'b0;
      frame_err   <= 1'b0;
      reg_written <= '0;
      for (int i = 0; i < NUM_REGS; i++) bank[i] <= '0;
    end else begin
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (start_frame) begin
        shifter <= '0;
        bit_cnt <= '0;
      end else if (shift_en) begin
        shifter <= {shifter[FRAME_W-2:0], sdata_s};
        if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + CNT_W'(1);
      end
      if (commit) begin
        bank[commit_idx]        <= shifter;
        reg_written[commit_idx] <= 1'b1;
        word_o                  <= shifter;
        word_idx                <= commit_idx;
        word_valid              <= 1'b1;
      end
      if (discard) frame_err <= 1'b1;
    end
  end

  assign all_written = &reg_written;
  assign ramp_en     = bank[IDX_R0][R0_RAMP_BIT];
  assign int_o       = bank[IDX_R0][R0_INT_MSB:R0_INT_LSB];
  assign frac_o      = {bank[IDX_R0][R0_FRAC_MSB:R0_FRAC_LSB], bank[IDX_R1][R1_FRAC_MSB:R1_FRAC_LSB]};

  // Only R0/R1 feed outputs; the rest of the bank and spare edges are kept for inspection
  logic unused_edges;
  logic unused_bank;
  assign unused_edges = ^{sclk_s, sclk_fall, le_s, sdata_rise, sdata_fall};
  always_comb begin
    unused_bank = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) unused_bank = unused_bank ^ (^bank[i]);
  end

endmodule

// File: tb/tb_adf4158_cfg_rx.sv
// Self-checking bench for adf4158_cfg_rx: table vectors, a mid-frame reset
// sequence and randomized frames checked against a shadow-register model.
module tb_adf4158_cfg_rx;

  localparam int SYNC = 2;

  logic        clk;
  logic        rst;
  logic        sclk;
  logic        sdata;
  logic        le;
  logic [31:0] word_o;
  logic        word_valid;
  logic [3:0]  word_idx;
  logic        frame_err;
  logic [9:0]  reg_written;
  logic        all_written;
  logic        ramp_en;
  logic [11:0] int_o;
  logic [24:0] frac_o;

  adf4158_cfg_rx #(.SYNC_STAGES(SYNC), .FRAME_BITS(32)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .sdata(sdata), .le(le),
    .word_o(word_o), .word_valid(word_valid), .word_idx(word_idx),
    .frame_err(frame_err), .reg_written(reg_written), .all_written(all_written),
    .ramp_en(ramp_en), .int_o(int_o), .frac_o(frac_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Pulse monitor, sampled on the falling clock edge
  int          valid_tot = 0;
  int          err_tot   = 0;
  int          both_tot  = 0;
  logic [3:0]  last_idx  = '0;
  logic [31:0] last_word = '0;

  always @(negedge clk) begin
    if (word_valid) begin
      valid_tot <= valid_tot + 1;
      last_idx  <= word_idx;
      last_word <= word_o;
    end
    if (frame_err) err_tot <= err_tot + 1;
    if (word_valid && frame_err) both_tot <= both_tot + 1;
  end

  // Reference model: shadow bank and written mask
  logic [31:0] m_bank [10];
  logic [9:0]  m_mask;

  function automatic logic [3:0] model_idx(input logic [31:0] w);
    int a;
    a = int'(w[2:0]);
    if (a < 5)       return 4'(a);
    else if (a == 7) return 4'd9;
    else             return 4'(5 + 2 * (a - 5) + (w[23] ? 0 : 1));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 10; i++) m_bank[i] = '0;
    m_mask = '0;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    checkOutput({tag, " reg_written"}, 64'(reg_written), 64'(m_mask));
    checkOutput({tag, " all_written"}, 64'(all_written), 64'(m_mask == 10'h3FF));
    checkOutput({tag, " ramp_en"}, 64'(ramp_en), 64'(m_bank[0][31]));
    checkOutput({tag, " int_o"}, 64'(int_o), 64'(m_bank[0][26:15]));
    checkOutput({tag, " frac_o"}, 64'(frac_o), 64'({m_bank[0][14:3], m_bank[1][27:15]}));
  endtask

  task automatic do_reset();
    rst = 1'b1; le = 1'b1; sclk = 1'b0; sdata = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    model_clear();
  endtask

  task automatic shift_bits(input logic [31:0] w, input int n);
    le = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      sdata = (i < 32) ? w[31 - i] : 1'($urandom_range(0, 1));
      repeat (2) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  // Raises le (optionally together with an extra sclk rise) and measures
  // falling edges until word_valid; 0 means no pulse within the budget
  task automatic finish_frame(input bit coincide, output int latency);
    repeat (3) @(negedge clk);
    latency = 0;
    if (coincide) begin
      sdata = 1'($urandom_range(0, 1));
      sclk  = 1'b1;
    end
    le = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 4) sclk = 1'b0;
      if (word_valid && latency == 0) latency = k;
    end
    sclk = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [31:0] w, input int n, input bit coincide,
                               input bit exp_valid, input logic [3:0] exp_idx, input string tag);
    int v0, e0, lat;
    v0 = valid_tot;
    e0 = err_tot;
    shift_bits(w, n);
    finish_frame(coincide, lat);
    if (exp_valid) begin
      m_bank[exp_idx] = w;
      m_mask[exp_idx] = 1'b1;
    end
    checkOutput({tag, " valid_pulses"}, 64'(valid_tot - v0), 64'(exp_valid ? 1 : 0));
    checkOutput({tag, " err_pulses"}, 64'(err_tot - e0), 64'(exp_valid ? 0 : 1));
    if (exp_valid) begin
      checkOutput({tag, " word_idx"}, 64'(last_idx), 64'(exp_idx));
      checkOutput({tag, " word_o"}, 64'(last_word), 64'(w));
      checkOutput({tag, " latency"}, 64'(lat), 64'(SYNC + 2));
    end
    check_regs(tag);
  endtask

  typedef struct {
    logic [31:0] word;
    int          nbits;
    bit          coincide;
    bit          exp_valid;
    logic [3:0]  exp_idx;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int e0;
    vecs.push_back('{32'hF88C0000, 32, 1'b0, 1'b1, 4'd0});
    vecs.push_back('{32'h00A1EB8D, 32, 1'b0, 1'b1, 4'd5});
    vecs.push_back('{32'h0021EB8D, 32, 1'b0, 1'b1, 4'd6});
    vecs.push_back('{32'h00037D07, 32, 1'b0, 1'b1, 4'd9});
    vecs.push_back('{32'h00800006, 32, 1'b0, 1'b1, 4'd7});
    vecs.push_back('{32'h00000006, 32, 1'b0, 1'b1, 4'd8});
    vecs.push_back('{32'h00800005, 32, 1'b0, 1'b1, 4'd5});
    vecs.push_back('{32'h00000005, 32, 1'b0, 1'b1, 4'd6});
    vecs.push_back('{32'h00180104, 32, 1'b0, 1'b1, 4'd4});
    vecs.push_back('{32'h00000043, 32, 1'b0, 1'b1, 4'd3});
    vecs.push_back('{32'h0040800A, 32, 1'b0, 1'b1, 4'd2});
    vecs.push_back('{32'h01238001, 32, 1'b0, 1'b1, 4'd1});
    vecs.push_back('{32'hF88C0000, 32, 1'b0, 1'b1, 4'd0});
    vecs.push_back('{32'h12345670, 31, 1'b0, 1'b0, 4'd0});
    vecs.push_back('{32'h12345671, 33, 1'b0, 1'b0, 4'd0});
    vecs.push_back('{32'h0ABCD001, 32, 1'b1, 1'b1, 4'd1});

    do_reset();
    checkOutput("reset word_o", 64'(word_o), 64'h0);
    checkOutput("reset word_idx", 64'(word_idx), 64'h0);
    checkOutput("reset word_valid", 64'(word_valid), 64'h0);
    checkOutput("reset frame_err", 64'(frame_err), 64'h0);
    check_regs("reset");

    for (int i = 0; i < vecs.size(); i++)
      applyStimulus(vecs[i].word, vecs[i].nbits, vecs[i].coincide,
                    vecs[i].exp_valid, vecs[i].exp_idx, $sformatf("vec%0d", i));
    checkOutput("sequence all_written", 64'(all_written), 64'h1);

    // Reset in the middle of a frame, then one clean R1 frame
    e0 = err_tot;
    shift_bits(32'hDEADBEEF, 16);
    do_reset();
    checkOutput("midreset no_err", 64'(err_tot - e0), 64'h0);
    checkOutput("midreset mask", 64'(reg_written), 64'h0);
    applyStimulus(32'h07FF8009, 32, 1'b0, 1'b1, 4'd1, "postreset_r1");
    checkOutput("postreset frac_o", 64'(frac_o), 64'(32'h07FF8009 >> 15) & 64'h1FFF);

    // Randomized frames against the model
    for (int i = 0; i < 16; i++) begin
      logic [31:0] w;
      int          n;
      int          r;
      bit          co;
      w  = $urandom;
      r  = $urandom_range(0, 4);
      n  = (r == 0) ? 31 : (r == 1) ? 33 : 32;
      co = (n == 32) && ($urandom_range(0, 1) == 1);
      applyStimulus(w, n, co, n == 32, model_idx(w), $sformatf("rand%0d", i));
    end

    checkOutput("valid_and_err_overlap", 64'(both_tot), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #5_000_000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] time limit reached");
  end

endmodule

// File: doc/adf4158_cfg_rx.md
Name: adf4158_cfg_rx

Overview:
- Receive-side model of the ADF4158 3-wire serial configuration interface (CLK/DATA/LE).
- Oversamples the pins with one fast system clock and shifts DATA MSB-first on each serial-clock rising edge while LE is low.
- On LE rising edge, validates the 32-bit frame, decodes the register address, and updates a 10-entry shadow bank.
- Used in loopback benches and the on-board monitor, so the FPGA can confirm what the synthesizer configurator actually sent.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on each asynchronous input (sclk, sdata, le); legal range 2..4.
- FRAME_BITS, 32: bits per valid frame.

Ports:
- clk  in  1  system clock, at least 4x the serial clock (e.g. 120 MHz against a 20 MHz serial clock).
- rst  in  1  synchronous, active-high reset.
- sclk  in  1  serial clock from the configurator; DATA is valid on its rising edge.
- sdata  in  1  serial data, MSB first.
- le  in  1  load enable; low while shifting, rising edge latches the frame.
- word_o  out  32  last accepted frame.
- word_valid  out  1  one-cycle pulse when word_o and word_idx update.
- word_idx  out  4  shadow index of the accepted frame, 0..9.
- frame_err  out  1  one-cycle pulse when a frame is discarded.
- reg_written  out  10  sticky mask, bit i set once index i has been written.
- all_written  out  1  equals &reg_written.
- ramp_en  out  1  shadow R0[31].
- int_o  out  12  shadow R0[26:15].
- frac_o  out  25  {R0[14:3], R1[27:15]}.

Behaviour:
- Reset (synchronous, active-high; clk is the only clock):
  - Every output, the shadow bank, the shifter and the bit counter go to 0.
  - The synchronizer history is loaded with le=1 and sclk=0, so no spurious edge is seen on the first cycle after reset.
  - A reset mid-frame drops the partial frame with no frame_err.
- Synchronizer and edge detection: each input passes through SYNC_STAGES flops. Edges are detected by comparing the last synchronized stage against its one-cycle-delayed copy.
- State machine:
  - IDLE: le falling edge -> SHIFT; clear bit_cnt and the shifter.
  - SHIFT: each sclk rising edge shifts in sdata (shifter <= {shifter[30:0], sdata}) and increments bit_cnt, saturating at FRAME_BITS+1. An le rising edge -> LATCH.
  - LATCH (one cycle), then return to IDLE:
    - bit_cnt == FRAME_BITS: commit the frame.
    - Any other count (short or overrun): pulse frame_err, leave the bank unchanged.
- Simultaneous sclk rise and le rise in the same sampled cycle: the le edge wins and that sclk edge is not shifted.
- sclk edges while le is high are ignored.
- Index decode (constants in the package), from address A = word[2:0] and select bit S = word[23]:
  - A=0..4 -> idx 0..4.
  - A=5: S=1 -> idx 5, S=0 -> idx 6.
  - A=6: S=1 -> idx 7, S=0 -> idx 8.
  - A=7 -> idx 9.
- Commit (the LATCH cycle):
  - Write bank[idx] and set reg_written[idx].
  - Drive word_o, word_idx and word_valid=1.
  - Latency: SYNC_STAGES+2 clk cycles from le going high at the pin to word_valid high.
- Register semantics: the bank is last-write-wins. ramp_en, int_o and frac_o are combinational from the bank and change in the cycle after commit.
- word_valid and frame_err are never asserted in the same cycle.

Decomposition:
- Package adf4158_pkg holds:
  - shadow index constants IDX_R0..IDX_R7 (IDX_R5_P1=5, IDX_R5_P2=6, IDX_R6_P1=7, IDX_R6_P2=8, IDX_R7=9);
  - the address field width, the select-bit position (23), and the R0/R1 field slice constants;
  - a shared decode function returning the index.
- One sub-module: adf4158_pin_sync. It is the synchronizer plus rise/fall edge detector, instantiated for sclk and le; sdata uses its sync path only.

Test Plan:
- Reset, then one frame 32'hF88C0000 -> word_valid one cycle, word_idx=0, ramp_en=1, int_o=280, frac_o=0, reg_written=10'b0000000001.
- Frame 32'h00A1EB8D (A=5, S=1), then 32'h0021EB8D (S=0) -> idx 5 then idx 6, both mask bits set, word_o matches each frame.
- Full 10-frame sequence R7..R0 (R7 frame = 32'h00037D07 -> idx 9) -> all_written=1 after the last frame; frame_err never pulses.
- 31-bit frame, then a 33-bit frame -> frame_err pulses twice, no word_valid, bank and mask unchanged.
- rst asserted after 16 bits of a frame, then a clean R1 frame -> no frame_err, only idx 1 written, frac_o reflects the new R1[27:15].
- sclk rise coincident with le rise on the 33rd edge -> frame accepted as 32 bits, word_valid pulses.
